// File: rtl/countdown_pkg.sv
// Shared types and BCD helpers for the countdown sequencing controller.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } cd_state_t;

  localparam logic [7:0] BCD_ZERO = 8'h00;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = value[7:4];
    lo = value[3:0];
    if (lo >= 4'd9) begin
      lo = 4'd0;
      hi = (hi >= 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  // Two-digit BCD decrement, 00 wraps to 99.
  function automatic logic [7:0] bcd_dec(input logic [7:0] value);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = value[7:4];
    lo = value[3:0];
    if (lo == 4'd0) begin
      lo = 4'd9;
      hi = (hi == 4'd0) ? 4'd9 : hi - 4'd1;
    end else begin
      lo = lo - 4'd1;
    end
    return {hi, lo};
  endfunction

endpackage

// File: rtl/countdown_controller_prescaler.sv
// Free-running divider shared by the RUN cadence and the alarm timer.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick_o
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + W'(1);
    end
  end

  // Flags the terminal count; the owner qualifies it with its own enable so the
  // decision to advance never loops back through this output.
  assign tick_o = (count == LAST);

endmodule

// File: rtl/countdown_controller.sv
// Sequencing FSM for the two-digit BCD countdown: preset edit, run/pause, alarm.
module countdown_controller
  import countdown_pkg::*;
#(
  parameter int         TICK_DIV       = 50_000_000,
  parameter int         ALARM_SECS     = 5,
  parameter logic [7:0] PRESET_DEFAULT = 8'h15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       inc,
  input  logic       dec,
  input  logic       zero,
  output logic       tick,
  output logic       load,
  output logic [3:0] preset_h,
  output logic [3:0] preset_l,
  output logic       running,
  output logic       alarm,
  output logic [1:0] state
);

  localparam int SW = $clog2(ALARM_SECS + 1);
  localparam logic [SW-1:0] SECS_LAST = SW'(ALARM_SECS - 1);

  cd_state_t     state_q;
  cd_state_t     state_next;
  logic [7:0]    preset;
  logic [7:0]    preset_next;
  logic [SW-1:0] secs;
  logic [SW-1:0] secs_next;
  logic          load_next;
  logic          tick_next;
  logic          pre_clr;
  logic          pre_en;
  logic          pre_last;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clr   (pre_clr),
    .en    (pre_en),
    .tick_o(pre_last)
  );

  // The prescaler only advances while the state is held, so the edge that
  // pauses the run also freezes the count at the value it had.
  always_comb begin
    state_next  = state_q;
    preset_next = preset;
    secs_next   = secs;
    load_next   = 1'b0;
    tick_next   = 1'b0;
    pre_clr     = 1'b0;
    pre_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          load_next = 1'b1;
        end else if (start_stop && preset != BCD_ZERO) begin
          state_next = RUN;
          pre_clr    = 1'b1;
        end else if (inc ^ dec) begin
          preset_next = inc ? bcd_inc(preset) : bcd_dec(preset);
          load_next   = 1'b1;
        end
      end
      RUN: begin
        if (clear) begin
          state_next = IDLE;
          load_next  = 1'b1;
        end else if (zero) begin
          state_next = ALARM;
          pre_clr    = 1'b1;
          secs_next  = '0;
        end else if (start_stop) begin
          state_next = PAUSE;
        end else begin
          pre_en    = 1'b1;
          tick_next = pre_last;
        end
      end
      PAUSE: begin
        if (clear) begin
          state_next = IDLE;
          load_next  = 1'b1;
        end else if (start_stop) begin
          state_next = RUN;
        end
      end
      ALARM: begin
        if (clear || start_stop || (pre_last && secs == SECS_LAST)) begin
          state_next = IDLE;
          load_next  = 1'b1;
          secs_next  = '0;
        end else begin
          pre_en = 1'b1;
          if (pre_last) begin
            secs_next = secs + SW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      preset  <= PRESET_DEFAULT;
      secs    <= '0;
      tick    <= 1'b0;
      load    <= 1'b0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state_q <= state_next;
      preset  <= preset_next;
      secs    <= secs_next;
      tick    <= tick_next;
      load    <= load_next;
      running <= (state_next == RUN);
      alarm   <= (state_next == ALARM);
    end
  end

  assign preset_h = preset[7:4];
  assign preset_l = preset[3:0];
  assign state    = state_q;

endmodule
